// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, coin codes, coin values and price table for the vending controller
package vend_pkg;
  typedef enum logic [2:0] {IDLE, CREDIT, CHECK, VEND, CHANGE} state_t;
  typedef enum logic [1:0] {COIN_500, COIN_1000, COIN_2000, COIN_5000} coin_t;
  localparam logic [15:0] PRICE [8] = '{16'd500, 16'd1000, 16'd1500, 16'd2000,
                                        16'd2500, 16'd3000, 16'd4000, 16'd5000};
  function automatic logic [15:0] coin_value(input logic [1:0] code);
    return code == COIN_5000 ? 16'd5000 :
           code == COIN_2000 ? 16'd2000 :
           code == COIN_1000 ? 16'd1000 : 16'd500;
  endfunction
endpackage

// File: rtl/vend_transaction_ctrl_if.sv
// vend_transaction_ctrl_if: front-end, inventory and payout signals of the transaction controller
interface vend_transaction_ctrl_if;
  logic        coin_valid;
  logic [1:0]  coin;
  logic        select_valid;
  logic [2:0]  product_id;
  logic        cancel;
  logic        stock_empty;
  logic        change_ready;
  logic [15:0] credit;
  logic [2:0]  state;
  logic [2:0]  vend_id;
  logic        did_buy;
  logic        coin_reject;
  logic        err_sold_out;
  logic        err_funds;
  logic        change_valid;
  logic [1:0]  change_coin;
  logic        timeout;
  modport master (
    output coin_valid, coin, select_valid, product_id, cancel, stock_empty, change_ready,
    input  credit, state, vend_id, did_buy, coin_reject, err_sold_out, err_funds,
           change_valid, change_coin, timeout
  );
  modport slave (
    input  coin_valid, coin, select_valid, product_id, cancel, stock_empty, change_ready,
    output credit, state, vend_id, did_buy, coin_reject, err_sold_out, err_funds,
           change_valid, change_coin, timeout
  );
endinterface

// File: rtl/vend_transaction_ctrl_change_select.sv
// change_select: greedy pick of the largest coin not exceeding the remaining credit
module change_select
  import vend_pkg::*;
(
  input  logic [15:0] credit_i,
  output logic [1:0]  code_o,
  output logic [15:0] value_o
);
  always_comb begin
    code_o  = credit_i >= 16'd5000 ? COIN_5000 :
              credit_i >= 16'd2000 ? COIN_2000 :
              credit_i >= 16'd1000 ? COIN_1000 : COIN_500;
    value_o = coin_value(code_o);
  end
endmodule

// File: rtl/vend_transaction_ctrl.sv
// vend_transaction_ctrl: credit/select/vend/change sequencer.
// Define VEND_TIMEOUT_EN to refund automatically after TIMEOUT_CYCLES idle cycles in CREDIT.
module vend_transaction_ctrl
  import vend_pkg::*;
#(
  parameter logic [15:0] CREDIT_MAX     = 16'd20000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input logic                    clk,
  input logic                    reset,
  vend_transaction_ctrl_if.slave bus
);
  state_t      state_q, state_d;
  logic [15:0] credit_q, credit_d;
  logic [2:0]  vend_id_q, vend_id_d;
  logic [15:0] coin_val, coin_sum, price, chg_value;
  logic [1:0]  chg_code;
  logic        coin_reject, err_sold_out, err_funds, timeout_pulse, expired;
  assign coin_val = coin_value(bus.coin);
  assign coin_sum = credit_q + coin_val;
  assign price    = PRICE[vend_id_q];
  change_select u_chg (.credit_i(credit_q), .code_o(chg_code), .value_o(chg_value));
`ifdef VEND_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;
  assign idle_d  = (state_q != CREDIT || bus.coin_valid || bus.select_valid || bus.cancel)
                   ? '0 : idle_q + 16'd1;
  assign expired = idle_q == TIMEOUT_CYCLES - 16'd1;
  always_ff @(posedge clk) idle_q <= reset ? '0 : idle_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expired        = 1'b0;
`endif
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    vend_id_d     = vend_id_q;
    coin_reject   = 1'b0;
    err_sold_out  = 1'b0;
    err_funds     = 1'b0;
    timeout_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        credit_d = bus.coin_valid ? coin_val : credit_q;
        state_d  = bus.coin_valid ? CREDIT : IDLE;
      end
      CREDIT: begin
        // cancel beats coin beats select beats timeout
        if (bus.cancel) begin
          coin_reject = bus.coin_valid;
          state_d     = CHANGE;
        end else if (bus.coin_valid) begin
          coin_reject = coin_sum > CREDIT_MAX;
          credit_d    = coin_reject ? credit_q : coin_sum;
        end else if (bus.select_valid) begin
          vend_id_d = bus.product_id;
          state_d   = CHECK;
        end else if (expired) begin
          timeout_pulse = 1'b1;
          state_d       = CHANGE;
        end
      end
      CHECK: begin
        coin_reject  = bus.coin_valid;
        err_sold_out = bus.stock_empty;
        err_funds    = !bus.stock_empty && credit_q < price;
        state_d      = (bus.stock_empty || credit_q < price) ? CREDIT : VEND;
      end
      VEND: begin
        coin_reject = bus.coin_valid;
        credit_d    = credit_q - price;
        state_d     = credit_q != price ? CHANGE : IDLE;
      end
      CHANGE: begin
        coin_reject = bus.coin_valid;
        credit_d    = (bus.change_ready && credit_q != 0) ? credit_q - chg_value : credit_q;
        state_d     = credit_d == 0 ? IDLE : CHANGE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      credit_q  <= '0;
      vend_id_q <= '0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      vend_id_q <= vend_id_d;
    end
  end
  assign bus.credit       = credit_q;
  assign bus.state        = state_q;
  assign bus.vend_id      = vend_id_q;
  assign bus.did_buy      = state_q == VEND;
  assign bus.coin_reject  = coin_reject;
  assign bus.err_sold_out = err_sold_out;
  assign bus.err_funds    = err_funds;
  assign bus.change_valid = state_q == CHANGE && credit_q != 0;
  assign bus.change_coin  = chg_code;
  assign bus.timeout      = timeout_pulse;
endmodule

// File: tb/tb_vend_transaction_ctrl.sv
// tb_vend_transaction_ctrl: directed plus random transactions checked against a transaction-level credit model
module tb_vend_transaction_ctrl;
  import vend_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0, passed = 0, fails = 0;
  int m_credit = 0;
  bit m_active = 1'b0;
  int prices [8] = '{500, 1000, 1500, 2000, 2500, 3000, 4000, 5000};
  vend_transaction_ctrl_if bus();
  vend_transaction_ctrl #(.CREDIT_MAX(16'd20000), .TIMEOUT_CYCLES(16'd1000)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;

  function automatic int val(input int c);
    return c == 3 ? 5000 : c == 2 ? 2000 : c == 1 ? 1000 : 500;
  endfunction
  function automatic int greedy_code(input int r);
    return r >= 5000 ? 3 : r >= 2000 ? 2 : r >= 1000 ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input int c);
    bit rej;
    rej = m_active && (m_credit + val(c) > 20000);
    bus.coin_valid = 1'b1;
    bus.coin = 2'(c);
    @(negedge clk);
    chk("coin_reject", bus.coin_reject, rej);
    chk("timeout_idle", bus.timeout, 0);
    step();
    bus.coin_valid = 1'b0;
    if (!rej) m_credit += val(c);
    m_active = 1'b1;
    chk("credit_after_coin", bus.credit, m_credit);
    chk("state_after_coin", bus.state, CREDIT);
  endtask

  task automatic payout(input int hold, input bit coin_in);
    int rem, n;
    bit rdy;
    rem = m_credit;
    n = 0;
    while (rem > 0) begin
      rdy = n >= hold && $urandom_range(0, 2) != 0;
      bus.change_ready = rdy;
      bus.coin_valid = coin_in && n == 0;
      bus.coin = 2'd3;
      @(negedge clk);
      chk("change_valid", bus.change_valid, 1);
      chk("change_coin", bus.change_coin, greedy_code(rem));
      if (coin_in && n == 0) chk("coin_reject_change", bus.coin_reject, 1);
      step();
      bus.change_ready = 1'b0;
      bus.coin_valid = 1'b0;
      if (rdy) rem -= val(greedy_code(rem));
      n++;
    end
    m_credit = 0;
    m_active = 1'b0;
    chk("state_after_payout", bus.state, IDLE);
    chk("credit_after_payout", bus.credit, 0);
    @(negedge clk);
    chk("change_valid_idle", bus.change_valid, 0);
    step();
  endtask

  task automatic cancel(input bit with_coin, input int hold);
    bus.cancel = 1'b1;
    bus.coin_valid = with_coin;
    bus.coin = 2'd0;
    @(negedge clk);
    chk("coin_reject_cancel", bus.coin_reject, with_coin);
    step();
    bus.cancel = 1'b0;
    bus.coin_valid = 1'b0;
    chk("state_after_cancel", bus.state, CHANGE);
    chk("credit_after_cancel", bus.credit, m_credit);
    payout(hold, 1'b0);
  endtask

  task automatic select(input int id, input int empty);
    bit buy, sold;
    sold = empty != 0;
    buy = !sold && m_credit >= prices[id];
    bus.select_valid = 1'b1;
    bus.product_id = 3'(id);
    bus.stock_empty = sold;
    step();
    bus.select_valid = 1'b0;
    @(negedge clk);
    chk("state_check", bus.state, CHECK);
    chk("err_sold_out", bus.err_sold_out, sold);
    chk("err_funds", bus.err_funds, !sold && !buy);
    chk("did_buy_early", bus.did_buy, 0);
    step();
    bus.stock_empty = 1'b0;
    if (buy) begin
      @(negedge clk);
      chk("did_buy", bus.did_buy, 1);
      chk("vend_id", bus.vend_id, id);
      step();
      m_credit -= prices[id];
      chk("credit_after_vend", bus.credit, m_credit);
      chk("state_after_vend", bus.state, m_credit > 0 ? CHANGE : IDLE);
      chk("did_buy_once", bus.did_buy, 0);
      if (m_credit > 0) payout(0, 1'b0);
      m_active = 1'b0;
    end else begin
      chk("state_after_err", bus.state, CREDIT);
      chk("credit_after_err", bus.credit, m_credit);
    end
  endtask

  initial begin
    int n;
    bus.coin_valid = 1'b0;
    bus.coin = 2'd0;
    bus.select_valid = 1'b0;
    bus.product_id = 3'd0;
    bus.cancel = 1'b0;
    bus.stock_empty = 1'b0;
    bus.change_ready = 1'b0;
    repeat (3) step();
    chk("rst_state", bus.state, IDLE);
    chk("rst_credit", bus.credit, 0);
    chk("rst_vend_id", bus.vend_id, 0);
    chk("rst_change_coin", bus.change_coin, 0);
    chk("rst_change_valid", bus.change_valid, 0);
    chk("rst_strobes", {bus.did_buy, bus.coin_reject, bus.err_sold_out, bus.err_funds, bus.timeout}, 0);
    reset = 1'b0;
    step();
    // basic vend with change, insufficient funds, sold out
    coin(3); select(3, 0);
    coin(0); select(7, 0); coin(3); select(7, 0);
    coin(2); select(2, 1); cancel(1'b0, 0);
    // cancel with backpressure, then exact payment
    coin(2); coin(1); coin(0); cancel(1'b0, 5);
    coin(1); select(1, 0);
    // credit ceiling, coin during payout
    repeat (4) coin(3);
    coin(0);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    payout(2, 1'b1);
    // coincident events and ignored inputs in IDLE
    bus.select_valid = 1'b1;
    bus.cancel = 1'b1;
    step();
    bus.select_valid = 1'b0;
    bus.cancel = 1'b0;
    chk("idle_ignores", bus.state, IDLE);
    coin(1);
    bus.coin_valid = 1'b1;
    bus.coin = 2'd0;
    bus.select_valid = 1'b1;
    @(negedge clk);
    chk("coin_sel_accept", bus.coin_reject, 0);
    step();
    bus.coin_valid = 1'b0;
    bus.select_valid = 1'b0;
    m_credit += 500;
    chk("coin_sel_state", bus.state, CREDIT);
    chk("coin_sel_credit", bus.credit, m_credit);
    cancel(1'b1, 0);
    // reset in the middle of a payout
    coin(3); coin(3);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    bus.change_ready = 1'b1;
    step();
    bus.change_ready = 1'b0;
    chk("partial_payout", bus.credit, 5000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_credit = 0;
    m_active = 1'b0;
    chk("midpay_rst_state", bus.state, IDLE);
    chk("midpay_rst_credit", bus.credit, 0);
    chk("midpay_rst_valid", bus.change_valid, 0);
    // random transactions
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) coin($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) cancel(1'($urandom_range(0, 1)), 0);
      else begin
        select($urandom_range(0, 7), $urandom_range(0, 4) == 0 ? 1 : 0);
        if (m_active) cancel(1'b0, $urandom_range(0, 3));
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
